// File: rtl/jtag_pkg.sv
// Shared types and default widths for the JTAG memory bridge.
package jtag_pkg;

    localparam int JTAG_AW = 32;
    localparam int JTAG_DW = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_REQ  = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [JTAG_AW-1:0] addr;
        logic [JTAG_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/jtag_wr_fifo.sv
// Synchronous write queue. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter register.
module jtag_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW   = $clog2(DEPTH);
    localparam int PTRW = PW + 1;

    logic [PTRW-1:0]  wptr_q, wptr_d;
    logic [PTRW-1:0]  rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[PW-1:0]];

    // A pop in the same cycle frees a slot, so a push on a full queue still lands.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer advance.
    always_comb begin
        wptr_d = wptr_q + PTRW'(push_ok);
        rptr_d = rptr_q + PTRW'(pop_ok);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/jtag_mem_bridge.sv
// Memory-side stage of the JTAG debug address chain: queues JTAG writes,
// drains them onto a single-outstanding req/gnt port, and re-reads the
// current JTAG address whenever it moves or is written.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | nothing outstanding; writes win over a pending read
// ST_WR_REQ  | presenting FIFO head as a write, waiting for mem_gnt
// ST_RD_REQ  | presenting latched read address, waiting for mem_gnt
// ST_RD_WAIT | read granted, waiting for mem_rvalid
module jtag_mem_bridge
    import jtag_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = JTAG_AW,
    parameter int DW         = JTAG_DW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              jtag_wren,
    input  logic [AW-1:0]     jtag_addr,
    input  logic [DW-1:0]     jtag_wdata,
    output logic [DW-1:0]     jtag_rdata,
    output logic              jtag_rd_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata,
    output logic              overflow
);

    localparam int EW = AW + DW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state_q, state_d;
    logic [EW-1:0]   fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            push_acc;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   head_addr;
    logic [DW-1:0]   head_data;

    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic            rd_pending_q, rd_pending_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            overflow_q, overflow_d;
    logic            set_pend;
    logic            rd_grant;
    logic            rd_done;

    jtag_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_wr_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (jtag_wren),
        .pop_i   (fifo_pop),
        .wdata_i ({jtag_addr, jtag_wdata}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_addr = fifo_head[EW-1:DW];
    assign head_data = fifo_head[DW-1:0];
    assign fifo_pop  = (state_q == ST_WR_REQ) && mem_gnt;
    assign push_acc  = jtag_wren && (!fifo_full || fifo_pop);
    assign rd_grant  = (state_q == ST_RD_REQ) && mem_gnt;
    assign rd_done   = (state_q == ST_RD_WAIT) && mem_rvalid;

    // Any accepted push either targets rd_addr or moves it, so both cases re-arm the read.
    assign set_pend  = (jtag_addr != rd_addr_q) || push_acc;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WR_REQ;
                end else if (rd_pending_q) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (mem_gnt) begin
                    state_d = (fifo_count > CW'(1)) ? ST_WR_REQ : ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request outputs; write path is held by the FIFO head, read path by req_addr_q.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr << 3;
                mem_wdata = head_data;
            end
            ST_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q << 3;
            end
            default: ;
        endcase
    end

    // Read tracking: rd_addr follows JTAG, req_addr freezes the address actually requested.
    always_comb begin
        rd_addr_d    = set_pend ? jtag_addr : rd_addr_q;
        rd_pending_d = set_pend ? 1'b1 : (rd_grant ? 1'b0 : rd_pending_q);
        req_addr_d   = ((state_q == ST_IDLE) && (state_d == ST_RD_REQ)) ? rd_addr_q : req_addr_q;
        rdata_d      = rd_done ? mem_rdata : rdata_q;
        rd_valid_d   = set_pend ? 1'b0 : (rd_done ? !rd_pending_q : rd_valid_q);
        overflow_d   = overflow_q | (jtag_wren & fifo_full & ~fifo_pop);
    end

    // Datapath registers; rd_pending resets high so address 0 is read first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_q    <= '0;
            req_addr_q   <= '0;
            rd_pending_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rdata_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            rd_addr_q    <= rd_addr_d;
            req_addr_q   <= req_addr_d;
            rd_pending_q <= rd_pending_d;
            rd_valid_q   <= rd_valid_d;
            rdata_q      <= rdata_d;
            overflow_q   <= overflow_d;
        end
    end

    assign jtag_rdata    = rdata_q;
    assign jtag_rd_valid = rd_valid_q;
    assign overflow      = overflow_q;
    assign mem_be        = '1;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Scoreboard bench for jtag_mem_bridge: expected memory requests are queued
// as stimulus is driven and matched against the request port; a small
// responder returns read data derived from the byte address.
module tb_jtag_mem_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jtag_wren;
    logic [31:0] jtag_addr;
    logic [63:0] jtag_wdata;
    logic [63:0] jtag_rdata;
    logic        jtag_rd_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        overflow;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] data;
    } req_t;

    req_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          rv_lat = 1;
    int          rd_cnt = 0;
    logic [31:0] rd_cnt_addr = '0;
    logic        force_rv = 1'b0;
    logic [63:0] force_data = '0;

    jtag_mem_bridge #(
        .FIFO_DEPTH (4),
        .AW         (32),
        .DW         (64)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .jtag_wren     (jtag_wren),
        .jtag_addr     (jtag_addr),
        .jtag_wdata    (jtag_wdata),
        .jtag_rdata    (jtag_rdata),
        .jtag_rd_valid (jtag_rd_valid),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rd_word(input logic [31:0] byte_addr);
        return 64'hDEADBEEF_00000001 + 64'(byte_addr);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_req(input logic we, input logic [31:0] addr, input logic [63:0] data);
        req_t e;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdv(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (jtag_rd_valid) seen = 1'b1;
        end
        chk(tag, 64'(jtag_rd_valid), 64'(1));
    endtask

    task automatic wait_rd_gnt();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && mem_gnt && !mem_we) seen = 1'b1;
        end
        chk("rd_gnt_seen", 64'(mem_req && mem_gnt && !mem_we), 64'(1));
    endtask

    task automatic wait_rvalid();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_rvalid) seen = 1'b1;
        end
        chk("rvalid_seen", 64'(mem_rvalid), 64'(1));
    endtask

    // Request monitor (scoreboard pop) and read responder.
    initial begin
        req_t e;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && mem_req === 1'b1) begin
                if (mem_gnt) begin
                    if (exp_q.size() == 0) begin
                        chk("req_unexpected", 64'(mem_req), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_we", 64'(mem_we), 64'(e.we));
                        chk("req_addr", 64'(mem_addr), 64'(e.addr));
                        chk("req_be", 64'(mem_be), 64'hFF);
                        if (e.we) chk("req_wdata", mem_wdata, e.data);
                    end
                    if (!mem_we) begin
                        rd_cnt      = rv_lat;
                        rd_cnt_addr = mem_addr;
                    end
                end else if (exp_q.size() != 0) begin
                    chk("hold_we", 64'(mem_we), 64'(exp_q[0].we));
                    chk("hold_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                end
            end
            @(posedge clk);
            #1;
            if (rstn !== 1'b1) rd_cnt = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_word(rd_cnt_addr);
                end else begin
                    mem_rvalid = 1'b0;
                end
            end else begin
                mem_rvalid = force_rv;
                mem_rdata  = force_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        jtag_wren  = 1'b0;
        jtag_addr  = '0;
        jtag_wdata = '0;
        mem_gnt    = 1'b1;
        repeat (3) tick();

        // Reset values
        @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", mem_wdata, 64'(0));
        chk("rst_rdata", jtag_rdata, 64'(0));
        chk("rst_rd_valid", 64'(jtag_rd_valid), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_mem_be", 64'(mem_be), 64'hFF);

        // First read after reset targets address 0
        exp_req(1'b0, 32'h0, '0);
        tick();
        rstn = 1'b1;
        wait_rdv("rdv_first");
        chk("rdata_first", jtag_rdata, 64'hDEADBEEF_00000001);

        // Address move: mem_req two cycles later
        tick();
        exp_req(1'b0, 32'h20, '0);
        jtag_addr = 32'h4;
        @(negedge clk);
        @(negedge clk);
        chk("rd_lat_n1", 64'(mem_req), 64'(0));
        @(negedge clk);
        chk("rd_lat_n2", 64'(mem_req), 64'(1));
        wait_rdv("rdv_addr4");
        chk("rdata_addr4", jtag_rdata, rd_word(32'h20));

        // Write to 0x10 followed by a re-read of 0x80
        tick();
        exp_req(1'b1, 32'h80, 64'h1122334455667788);
        exp_req(1'b0, 32'h80, '0);
        jtag_addr  = 32'h10;
        jtag_wdata = 64'h1122334455667788;
        jtag_wren  = 1'b1;
        tick();
        jtag_wren = 1'b0;
        @(negedge clk);
        chk("wr_lat_n1", 64'(mem_req), 64'(0));
        chk("rdv_clr_move", 64'(jtag_rd_valid), 64'(0));
        @(negedge clk);
        chk("wr_lat_n2_req", 64'(mem_req), 64'(1));
        chk("wr_lat_n2_we", 64'(mem_we), 64'(1));
        wait_rdv("rdv_after_wr");
        chk("rdata_after_wr", jtag_rdata, rd_word(32'h80));

        // Write to the address being displayed forces a re-read
        tick();
        exp_req(1'b1, 32'h80, 64'hCAFE_F00D_0000_0010);
        exp_req(1'b0, 32'h80, '0);
        jtag_wdata = 64'hCAFE_F00D_0000_0010;
        jtag_wren  = 1'b1;
        tick();
        jtag_wren = 1'b0;
        @(negedge clk);
        chk("rdv_clr_same_addr", 64'(jtag_rd_valid), 64'(0));
        wait_rdv("rdv_reread");
        chk("rdata_reread", jtag_rdata, rd_word(32'h80));

        // Address change while in RD_WAIT
        tick();
        rv_lat = 4;
        exp_req(1'b0, 32'h200, '0);
        jtag_addr = 32'h40;
        wait_rd_gnt();
        tick();
        exp_req(1'b0, 32'h208, '0);
        jtag_addr = 32'h41;
        wait_rvalid();
        rv_lat = 1;
        @(negedge clk);
        chk("rdata_stale", jtag_rdata, rd_word(32'h200));
        chk("rdv_stale", 64'(jtag_rd_valid), 64'(0));
        wait_rdv("rdv_new_addr");
        chk("rdata_new_addr", jtag_rdata, rd_word(32'h208));

        // Five writes with grant held low: fifth is dropped
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            jtag_addr  = 32'h20 + 32'(i);
            jtag_wdata = 64'hA5A5_0000_0000_0000 + 64'(i);
            jtag_wren  = 1'b1;
            if (i < 4) exp_req(1'b1, (32'h20 + 32'(i)) << 3, 64'hA5A5_0000_0000_0000 + 64'(i));
            if (i == 4) begin
                @(negedge clk);
                chk("ovf_before_drop", 64'(overflow), 64'(0));
            end
            tick();
        end
        jtag_wren = 1'b0;
        exp_req(1'b0, 32'h24 << 3, '0);
        @(negedge clk);
        chk("ovf_after_drop", 64'(overflow), 64'(1));
        repeat (3) tick();
        mem_gnt = 1'b1;
        wait_rdv("rdv_after_ovf");
        chk("rdata_after_ovf", jtag_rdata, rd_word(32'h24 << 3));
        chk("ovf_sticky", 64'(overflow), 64'(1));
        chk("sb_drain_ovf", 64'(exp_q.size()), 64'(0));

        // Reset, then push and pop on a full FIFO in the same cycle
        tick();
        rstn      = 1'b0;
        jtag_addr = '0;
        exp_q.delete();
        repeat (2) tick();
        exp_req(1'b0, 32'h0, '0);
        rstn = 1'b1;
        wait_rdv("rdv_rst2");
        chk("ovf_cleared", 64'(overflow), 64'(0));
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            jtag_addr  = 32'h30;
            jtag_wdata = 64'h5A5A_0000_0000_0000 + 64'(i);
            jtag_wren  = 1'b1;
            exp_req(1'b1, 32'h180, 64'h5A5A_0000_0000_0000 + 64'(i));
            tick();
        end
        jtag_wdata = 64'h5A5A_0000_0000_0004;
        mem_gnt    = 1'b1;
        exp_req(1'b1, 32'h180, 64'h5A5A_0000_0000_0004);
        tick();
        jtag_wren = 1'b0;
        mem_gnt   = 1'b0;
        @(negedge clk);
        chk("ovf_push_pop_full", 64'(overflow), 64'(0));
        tick();
        jtag_wdata = 64'h5A5A_0000_0000_0005;
        jtag_wren  = 1'b1;
        tick();
        jtag_wren = 1'b0;
        @(negedge clk);
        chk("ovf_still_full", 64'(overflow), 64'(1));
        exp_req(1'b0, 32'h180, '0);
        tick();
        mem_gnt = 1'b1;
        wait_rdv("rdv_after_full");
        chk("rdata_after_full", jtag_rdata, rd_word(32'h180));
        chk("sb_drain_full", 64'(exp_q.size()), 64'(0));

        // Reset during RD_WAIT, then a late rvalid
        tick();
        rv_lat = 5;
        exp_req(1'b0, 32'h280, '0);
        jtag_addr = 32'h50;
        wait_rd_gnt();
        tick();
        rstn      = 1'b0;
        exp_q.delete();
        jtag_addr = '0;
        mem_gnt   = 1'b0;
        @(negedge clk);
        chk("rst2_mem_req", 64'(mem_req), 64'(0));
        chk("rst2_rdata", jtag_rdata, 64'(0));
        chk("rst2_rd_valid", 64'(jtag_rd_valid), 64'(0));
        chk("rst2_overflow", 64'(overflow), 64'(0));
        tick();
        tick();
        rstn       = 1'b1;
        force_rv   = 1'b1;
        force_data = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        tick();
        force_rv = 1'b0;
        @(negedge clk);
        chk("late_rv_rdata", jtag_rdata, 64'(0));
        chk("late_rv_rd_valid", 64'(jtag_rd_valid), 64'(0));
        chk("late_rv_req", 64'(mem_req), 64'(1));
        chk("late_rv_we", 64'(mem_we), 64'(0));
        chk("late_rv_addr", 64'(mem_addr), 64'(0));
        tick();
        rv_lat = 1;
        exp_req(1'b0, 32'h0, '0);
        mem_gnt = 1'b1;
        wait_rdv("rdv_after_rst");
        chk("rdata_after_rst", jtag_rdata, rd_word(32'h0));
        chk("sb_drain_end", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
